bp_me_bedrock_reg_arbiter: RTL and testbench
============================================

# bp_me_bedrock_reg_arbiter

Round-robin arbiter that shares one BedRock register device port among `num_req_p` BedRock memory command/response streams. It sits between several requesters (CCE, loopback, debug) and a single register endpoint, such as a CSR block built on the BedRock-to-register bridge. It allows one outstanding transaction at a time and steers each response back to the requester that issued the command. An optional watchdog synthesizes responses for commands that the device never answers.

## Interface
- `bp_params_p`, `e_bp_default_cfg`: processor config; supplies `paddr_width_p`, `did_width_p`, `lce_id_width_p`, `lce_assoc_p`, and `mem_header_width_lp`.
- `num_req_p`, 2: number of requesters, ≥1. `lg_num_req_lp` = `BSG_SAFE_CLOG2(num_req_p)`.
- `timeout_p`, 1024: watchdog limit in cycles. Used only when the Configuration macro is defined.

Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i` in, 1: clock.
- `reset_i` in, 1: synchronous, active-high reset.

Requester side:
- `mem_cmd_header_i` in, `[num_req_p][mem_header_width_lp]`: per-requester command header.
- `mem_cmd_critical_i` in, `[num_req_p][64]`: per-requester write data.
- `mem_cmd_header_v_i` in, `[num_req_p]`: command valid.
- `mem_cmd_header_ready_and_o` out, `[num_req_p]`: command ready.
- `mem_resp_header_o` out, `[mem_header_width_lp]`: response header, shared bus.
- `mem_resp_critical_o` out, 64: response data, shared bus.
- `mem_resp_header_v_o` out, `[num_req_p]`: per-requester response valid; one-hot or zero.
- `mem_resp_header_ready_and_i` in, `[num_req_p]`: per-requester response ready.

Device side:
- `dev_cmd_header_o` out, `[mem_header_width_lp]`: device command header.
- `dev_cmd_critical_o` out, 64: device write data.
- `dev_cmd_header_v_o` out, 1: device command valid.
- `dev_cmd_header_ready_and_i` in, 1: device command ready.
- `dev_resp_header_i` in, `[mem_header_width_lp]`: device response header.
- `dev_resp_critical_i` in, 64: device response data.
- `dev_resp_header_v_i` in, 1: device response valid.
- `dev_resp_header_ready_and_o` out, 1: device response ready.
- `busy_o` out, 1: a transaction is outstanding (state is not `e_ready`).

## Operation
FSM states: `e_ready`, `e_wait`, and, with the macro only, `e_err`.

In `e_ready`:
- The round-robin arbiter picks `gnt` among the set `mem_cmd_header_v_i` bits, starting at pointer `rr_r`.
- The granted command passes combinationally to the device side. `dev_cmd_header_v_o` = OR of the valid bits.
- `mem_cmd_header_ready_and_o[gnt]` = `dev_cmd_header_ready_and_i`. All other ready bits are 0.
- On command handshake:
  - Latch `gnt` into `id_r`.
  - Latch the header into `hdr_r`.
  - Set `rr_r` = `gnt`+1, wrapping modulo `num_req_p`.
  - Go to `e_wait`.

In `e_wait`:
- All command ready bits are 0 and `dev_cmd_header_v_o` = 0.
- `mem_resp_header_v_o[id_r]` = `dev_resp_header_v_i`. Response header and data pass through.
- `dev_resp_header_ready_and_o` = `mem_resp_header_ready_and_i[id_r]`.
- On response handshake, go to `e_ready`.

Response routing and errors:
- Routing uses `id_r` only. The response header content does not affect routing.
- A device response that arrives in `e_ready` is a protocol error. It is not routed to any requester. `dev_resp_header_ready_and_o` = 0 in `e_ready`, except for the stale drain described under Configuration.

Arbitration is fair: a continuously valid requester waits at most `num_req_p`-1 transactions.

## Timing
- Command path from requester to device: 0 cycles, combinational pass-through.
- Response path from device to requester: 0 cycles, combinational.
- Minimum transaction: command handshake in cycle N, response handshake in cycle N+1, next grant in cycle N+2.
- Reset:
  - State goes to `e_ready`, with `rr_r`=0, `id_r`=0, and `busy_o`=0.
  - While `reset_i`=1, all `_v_o` and `_ready_and_o` outputs are forced to 0.
  - Asserting reset during `e_wait` abandons the transaction. No response is produced.
- With `num_req_p`=1, the arbiter degenerates to a pass-through with a single outstanding transaction.

## Configuration
Macro: `BP_ME_REG_ARB_WATCHDOG_EN`.

With the macro defined:
- A counter clears on entry to `e_wait` and increments each cycle spent in `e_wait`.
- When the counter reaches `timeout_p` with no response handshake, the FSM goes to `e_err`.
- In `e_err`, the arbiter drives `mem_resp_header_v_o[id_r]`=1 with `mem_resp_header_o`=`hdr_r` and `mem_resp_critical_o`=`64'hDEAD_BEEF_DEAD_BEEF`.
- On that response handshake, set `stale_r` and return to `e_ready`.
- While `stale_r`=1, the first device response is accepted and dropped, in any state, and `stale_r` is then cleared. If this coincides with a valid response in `e_wait`, the dropped response counts as the stale one.

Without the macro, there are no counter, `e_err`, or `stale_r` registers, and `e_wait` waits indefinitely.

## Test plan
1. Requester 0 only: uc_rd at addr 0x100. Device responds after 1 cycle with data 0x1234. Required: `mem_resp_header_v_o`=2'b01, critical=0x1234, `busy_o` high for exactly the wait cycles.
2. Both requesters valid continuously for 4 transactions. Required: grant order 0,1,0,1.
3. Requester 1 holds `mem_resp_header_ready_and_i`=0 for 5 cycles. Required: `dev_resp_header_ready_and_o`=0 for those cycles and no new command issued.
4. Reset asserted in `e_wait`. Required: all valid outputs 0 the cycle after reset is sampled, and `rr_r`=0.
5. With the macro defined and `timeout_p`=8, the device never responds. Required: cycle 8 after the command, the requester receives the DEAD_BEEF response. A later device response is dropped, and the next transaction completes normally.

Source files
------------

// File: rtl/bp_me_bedrock_reg_arbiter.sv
// bp_me_bedrock_reg_arbiter
// Round-robin arbiter sharing one BedRock register device port among
// num_req_p command/response streams. One transaction is outstanding at a
// time; the response is steered back to the requester that issued the
// command (routing uses the latched requester id, never header content).
// The command and response paths are combinational pass-throughs.
//
// Optional watchdog: define BP_ME_REG_ARB_WATCHDOG_EN to synthesize a
// DEAD_BEEF response for a command the device never answers, and to drop
// the late device response that eventually follows it.
//
// The header width is exposed directly as mem_header_width_p (the value the
// processor configuration would otherwise supply).

module bp_me_bedrock_reg_arbiter #(
    parameter int num_req_p          = 2,
    parameter int timeout_p          = 1024,
    parameter int mem_header_width_p = 64
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,

    input  logic [num_req_p-1:0][mem_header_width_p-1:0] mem_cmd_header_i,
    input  logic [num_req_p-1:0][63:0]                   mem_cmd_critical_i,
    input  logic [num_req_p-1:0]                         mem_cmd_header_v_i,
    output logic [num_req_p-1:0]                         mem_cmd_header_ready_and_o,
    output logic [mem_header_width_p-1:0]                mem_resp_header_o,
    output logic [63:0]                                  mem_resp_critical_o,
    output logic [num_req_p-1:0]                         mem_resp_header_v_o,
    input  logic [num_req_p-1:0]                         mem_resp_header_ready_and_i,

    output logic [mem_header_width_p-1:0]                dev_cmd_header_o,
    output logic [63:0]                                  dev_cmd_critical_o,
    output logic                                         dev_cmd_header_v_o,
    input  logic                                         dev_cmd_header_ready_and_i,
    input  logic [mem_header_width_p-1:0]                dev_resp_header_i,
    input  logic [63:0]                                  dev_resp_critical_i,
    input  logic                                         dev_resp_header_v_i,
    output logic                                         dev_resp_header_ready_and_o,
    output logic                                         busy_o
);

    localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam logic [lg_num_req_lp-1:0] last_id_lp = lg_num_req_lp'(num_req_p - 1);

    localparam logic [1:0] e_ready = 2'd0;
    localparam logic [1:0] e_wait  = 2'd1;

    // The watchdog needs at least one cycle in e_wait before giving up.
    if (timeout_p < 2) begin : g_bad_timeout
        $error("timeout_p must be at least 2");
    end

    logic [1:0]               state_r;
    logic [lg_num_req_lp-1:0] rr_r;
    logic [lg_num_req_lp-1:0] id_r;
    logic [lg_num_req_lp-1:0] gnt;
    logic                     gnt_v;
    logic                     stale;
    logic                     cmd_hs;
    logic                     resp_hs;

`ifdef BP_ME_REG_ARB_WATCHDOG_EN
    localparam logic [1:0] e_err = 2'd2;

    // cnt_r is 0 in the first e_wait cycle, so leaving at timeout_p-2 puts
    // the synthesized response exactly timeout_p cycles after the command.
    localparam int cnt_w_lp = $clog2(timeout_p);
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(timeout_p - 2);

    logic [cnt_w_lp-1:0]           cnt_r;
    logic                          stale_r;
    logic                          timeout_hit;
    logic                          err_hs;
    logic [mem_header_width_p-1:0] hdr_r;

    assign timeout_hit = (cnt_r == cnt_last_lp);
    assign err_hs      = (state_r == e_err) & mem_resp_header_ready_and_i[id_r];
    assign stale       = stale_r;

    // Wait-cycle counter: cleared by the command handshake, runs in e_wait.
    always_ff @(posedge clk_i) begin
        if (reset_i || cmd_hs)
            cnt_r <= '0;
        else if (state_r == e_wait)
            cnt_r <= cnt_r + 1'b1;
    end

    // Header of the outstanding command, replayed in the synthesized response.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            hdr_r <= '0;
        else if (cmd_hs)
            hdr_r <= mem_cmd_header_i[gnt];
    end

    // A timed-out command leaves one late device response to drop; setting
    // wins over a drain in the same cycle since a new orphan was just made.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            stale_r <= 1'b0;
        else if (err_hs)
            stale_r <= 1'b1;
        else if (stale_r && dev_resp_header_v_i)
            stale_r <= 1'b0;
    end
`else
    assign stale = 1'b0;
`endif

    // Pick the first valid requester at or after the round-robin pointer.
    always_comb begin
        logic [lg_num_req_lp-1:0] idx;
        idx   = '0;
        gnt   = '0;
        gnt_v = 1'b0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            idx = lg_num_req_lp'((int'(rr_r) + k) % num_req_p);
            if (mem_cmd_header_v_i[idx]) begin
                gnt   = idx;
                gnt_v = 1'b1;
            end
        end
    end

    assign cmd_hs  = (state_r == e_ready) & gnt_v & dev_cmd_header_ready_and_i;
    assign resp_hs = (state_r == e_wait) & ~stale & dev_resp_header_v_i
                   & mem_resp_header_ready_and_i[id_r];
    assign busy_o  = (state_r != e_ready);

    // Steer command and response handshakes according to the current state.
    always_comb begin
        mem_cmd_header_ready_and_o  = '0;
        dev_cmd_header_v_o          = 1'b0;
        dev_cmd_header_o            = mem_cmd_header_i[gnt];
        dev_cmd_critical_o          = mem_cmd_critical_i[gnt];
        mem_resp_header_v_o         = '0;
        mem_resp_header_o           = dev_resp_header_i;
        mem_resp_critical_o         = dev_resp_critical_i;
        dev_resp_header_ready_and_o = stale;
        case (state_r)
            e_ready: begin
                dev_cmd_header_v_o              = gnt_v;
                mem_cmd_header_ready_and_o[gnt] = gnt_v & dev_cmd_header_ready_and_i;
            end
            e_wait: begin
                if (!stale) begin
                    mem_resp_header_v_o[id_r]   = dev_resp_header_v_i;
                    dev_resp_header_ready_and_o = mem_resp_header_ready_and_i[id_r];
                end
            end
`ifdef BP_ME_REG_ARB_WATCHDOG_EN
            e_err: begin
                mem_resp_header_v_o[id_r] = 1'b1;
                mem_resp_header_o         = hdr_r;
                mem_resp_critical_o       = 64'hDEAD_BEEF_DEAD_BEEF;
            end
`endif
            default: ;
        endcase
        if (reset_i) begin
            mem_cmd_header_ready_and_o  = '0;
            dev_cmd_header_v_o          = 1'b0;
            mem_resp_header_v_o         = '0;
            dev_resp_header_ready_and_o = 1'b0;
        end
    end

    // Transaction FSM with round-robin pointer and owner id.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_ready;
            rr_r    <= '0;
            id_r    <= '0;
        end else begin
            case (state_r)
                e_ready: begin
                    if (cmd_hs) begin
                        state_r <= e_wait;
                        id_r    <= gnt;
                        rr_r    <= (gnt == last_id_lp) ? '0 : gnt + 1'b1;
                    end
                end
                e_wait: begin
                    if (resp_hs)
                        state_r <= e_ready;
`ifdef BP_ME_REG_ARB_WATCHDOG_EN
                    else if (timeout_hit)
                        state_r <= e_err;
`endif
                end
`ifdef BP_ME_REG_ARB_WATCHDOG_EN
                e_err: begin
                    if (mem_resp_header_ready_and_i[id_r])
                        state_r <= e_ready;
                end
`endif
                default: state_r <= e_ready;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_me_bedrock_reg_arbiter.sv
// Self-checking bench for bp_me_bedrock_reg_arbiter: a transaction-level
// model predicts every output each cycle; a vector table and hand-written
// sequences add targeted checks for grant order, stalls, reset and timeout.

module tb_bp_me_bedrock_reg_arbiter;
    localparam int N = 2;
    localparam int W = 64;
`ifdef BP_ME_REG_ARB_WATCHDOG_EN
    localparam int TO = 8;
    localparam bit WD = 1'b1;
`else
    localparam int TO = 1024;
    localparam bit WD = 1'b0;
`endif
    localparam logic [63:0] DEAD = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0][W-1:0] cmd_hdr;
    logic [N-1:0][63:0]  cmd_crit;
    logic [N-1:0]        cmd_v, cmd_rdy_o, resp_v_o, resp_rdy;
    logic [W-1:0]        resp_hdr_o, dev_hdr_o, dev_resp_hdr;
    logic [63:0]         resp_crit_o, dev_crit_o, dev_resp_crit;
    logic                dev_v_o, dev_cmd_rdy, dev_resp_v, dev_rrdy_o, busy_o;

    bp_me_bedrock_reg_arbiter #(.num_req_p(N), .timeout_p(TO), .mem_header_width_p(W)) dut (
        .clk_i(clk), .reset_i(reset),
        .mem_cmd_header_i(cmd_hdr), .mem_cmd_critical_i(cmd_crit),
        .mem_cmd_header_v_i(cmd_v), .mem_cmd_header_ready_and_o(cmd_rdy_o),
        .mem_resp_header_o(resp_hdr_o), .mem_resp_critical_o(resp_crit_o),
        .mem_resp_header_v_o(resp_v_o), .mem_resp_header_ready_and_i(resp_rdy),
        .dev_cmd_header_o(dev_hdr_o), .dev_cmd_critical_o(dev_crit_o),
        .dev_cmd_header_v_o(dev_v_o), .dev_cmd_header_ready_and_i(dev_cmd_rdy),
        .dev_resp_header_i(dev_resp_hdr), .dev_resp_critical_i(dev_resp_crit),
        .dev_resp_header_v_i(dev_resp_v), .dev_resp_header_ready_and_o(dev_rrdy_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Transaction-level model state.
    bit        m_busy, m_err, m_stale, m_found;
    int        m_owner, m_rr, m_age, m_gnt;
    logic [W-1:0] m_hdr;
    logic [N-1:0] e_cmd_rdy, e_resp_v;
    logic         e_dev_v, e_dev_rrdy, e_busy;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] gnt;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called right after a rising edge with inputs already driven.
    task automatic eval();
        #3;
        e_cmd_rdy = '0; e_resp_v = '0; e_dev_v = 1'b0; e_dev_rrdy = 1'b0;
        m_found = 1'b0; m_gnt = 0;
        e_busy = m_busy | m_err;
        for (int k = 0; k < N; k++)
            if (!m_found && cmd_v[(m_rr + k) % N]) begin
                m_found = 1'b1;
                m_gnt = (m_rr + k) % N;
            end
        if (!reset) begin
            if (m_err) begin
                e_resp_v[m_owner] = 1'b1;
                e_dev_rrdy = m_stale;
            end else if (m_busy) begin
                if (m_stale) e_dev_rrdy = 1'b1;
                else begin
                    e_resp_v[m_owner] = dev_resp_v;
                    e_dev_rrdy = resp_rdy[m_owner];
                end
            end else begin
                e_dev_v = m_found;
                if (m_found) e_cmd_rdy[m_gnt] = dev_cmd_rdy;
                e_dev_rrdy = m_stale;
            end
        end
        chk("cmd_ready", 64'(cmd_rdy_o), 64'(e_cmd_rdy));
        chk("dev_cmd_v", 64'(dev_v_o), 64'(e_dev_v));
        chk("resp_v", 64'(resp_v_o), 64'(e_resp_v));
        chk("dev_resp_ready", 64'(dev_rrdy_o), 64'(e_dev_rrdy));
        chk("busy", 64'(busy_o), 64'(e_busy));
        if (e_dev_v) begin
            chk("dev_cmd_header", dev_hdr_o, cmd_hdr[m_gnt]);
            chk("dev_cmd_critical", dev_crit_o, cmd_crit[m_gnt]);
        end
        if (|e_resp_v) begin
            chk("resp_header", resp_hdr_o, m_err ? m_hdr : dev_resp_hdr);
            chk("resp_critical", resp_crit_o, m_err ? DEAD : dev_resp_crit);
        end
    endtask

    // Advance one clock and apply the transaction rules to the model.
    task automatic adv();
        bit drain, set_stale;
        @(posedge clk);
        drain = m_stale && dev_resp_v;
        set_stale = 1'b0;
        if (reset) begin
            m_busy = 0; m_err = 0; m_stale = 0; m_rr = 0; m_owner = 0; m_age = 0;
        end else begin
            if (m_err) begin
                if (resp_rdy[m_owner]) begin m_err = 0; set_stale = 1'b1; end
            end else if (m_busy) begin
                if (!m_stale && dev_resp_v && resp_rdy[m_owner]) m_busy = 0;
                else if (WD && m_age + 1 == TO) begin m_busy = 0; m_err = 1; end
                else m_age++;
            end else if (m_found && dev_cmd_rdy) begin
                m_busy = 1; m_owner = m_gnt; m_rr = (m_gnt + 1) % N;
                m_age = 1; m_hdr = cmd_hdr[m_gnt];
            end
            if (set_stale) m_stale = 1'b1;
            else if (drain) m_stale = 1'b0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        cmd_v = '0; dev_cmd_rdy = 1'b0; dev_resp_v = 1'b0; resp_rdy = '0;
    endtask

    initial begin
        m_busy = 0; m_err = 0; m_stale = 0; m_rr = 0; m_owner = 0; m_age = 0; m_hdr = '0;
        cmd_hdr = '0; cmd_crit = '0; dev_resp_hdr = '0; dev_resp_crit = '0;
        idle_inputs();
        cmd_v = '1; dev_cmd_rdy = 1'b1; dev_resp_v = 1'b1; resp_rdy = '1;
        @(posedge clk); #1;
        // Reset cycle: every valid/ready output is forced low.
        eval(); adv();
        eval(); adv();
        reset = 1'b0;
        idle_inputs();

        // Vector table: grant sequence from rr=0 and response routing.
        tbl[0] = '{2'b01, 2'b01}; tbl[1] = '{2'b11, 2'b10}; tbl[2] = '{2'b11, 2'b01};
        tbl[3] = '{2'b11, 2'b10}; tbl[4] = '{2'b10, 2'b10}; tbl[5] = '{2'b01, 2'b01};
        tbl[6] = '{2'b10, 2'b10};
        for (int i = 0; i < 7; i++) begin
            cmd_v = tbl[i].v; dev_cmd_rdy = 1'b1; dev_resp_v = 1'b0; resp_rdy = '1;
            cmd_hdr[0] = 64'h100 + 64'(i); cmd_hdr[1] = 64'h200 + 64'(i);
            cmd_crit[0] = 64'hA0 + 64'(i); cmd_crit[1] = 64'hB0 + 64'(i);
            eval(); chk("tbl_grant", 64'(cmd_rdy_o), 64'(tbl[i].gnt)); adv();
            cmd_v = '0; dev_resp_v = 1'b1; dev_resp_crit = 64'hC0DE_0000 + 64'(i);
            eval(); chk("tbl_route", 64'(resp_v_o), 64'(tbl[i].gnt)); adv();
            idle_inputs();
        end

        // Both requesters continuously valid: grants alternate 0,1,0,1.
        for (int t = 0; t < 4; t++) begin
            cmd_v = 2'b11; dev_cmd_rdy = 1'b1; dev_resp_v = 1'b0; resp_rdy = 2'b11;
            eval(); chk("rr_grant", 64'(cmd_rdy_o), (t % 2 == 0) ? 64'h1 : 64'h2); adv();
            dev_resp_v = 1'b1;
            eval(); adv();
        end
        idle_inputs();

        // Requester 0 uc_rd at 0x100, device answers one cycle later.
        cmd_v = 2'b01; dev_cmd_rdy = 1'b1; cmd_hdr[0] = 64'h0000_0000_0000_0100;
        eval(); chk("t1_busy_idle", 64'(busy_o), 64'h0); chk("t1_dev_v", 64'(dev_v_o), 64'h1); adv();
        cmd_v = '0; dev_resp_v = 1'b0; resp_rdy = 2'b01;
        eval(); chk("t1_busy_w1", 64'(busy_o), 64'h1); adv();
        dev_resp_v = 1'b1; dev_resp_crit = 64'h1234;
        eval();
        chk("t1_resp_v", 64'(resp_v_o), 64'h1);
        chk("t1_crit", resp_crit_o, 64'h1234);
        chk("t1_busy_w2", 64'(busy_o), 64'h1);
        adv();
        dev_resp_v = 1'b0;
        eval(); chk("t1_busy_done", 64'(busy_o), 64'h0); adv();

        // Requester 1 stalls its response for 5 cycles; nothing else issues.
        cmd_v = 2'b11; dev_cmd_rdy = 1'b1;
        eval(); chk("t3_grant", 64'(cmd_rdy_o), 64'h2); adv();
        dev_resp_v = 1'b1; resp_rdy = 2'b01; dev_resp_crit = 64'h3333;
        for (int s = 0; s < 5; s++) begin
            eval();
            chk("t3_dev_rrdy", 64'(dev_rrdy_o), 64'h0);
            chk("t3_no_cmd", 64'({dev_v_o, cmd_rdy_o}), 64'h0);
            adv();
        end
        resp_rdy = 2'b11;
        eval(); chk("t3_release", 64'(dev_rrdy_o), 64'h1); adv();
        idle_inputs();

        // Reset during e_wait abandons the transaction and clears rr.
        cmd_v = 2'b01; dev_cmd_rdy = 1'b1;
        eval(); adv();
        reset = 1'b1; cmd_v = 2'b11; dev_resp_v = 1'b1; resp_rdy = 2'b11;
        eval(); chk("t4_in_reset", 64'({resp_v_o, dev_rrdy_o, cmd_rdy_o, dev_v_o}), 64'h0); adv();
        reset = 1'b0;
        eval();
        chk("t4_busy", 64'(busy_o), 64'h0);
        chk("t4_resp_v", 64'(resp_v_o), 64'h0);
        chk("t4_rr0", 64'(cmd_rdy_o), 64'h1);
        adv();
        cmd_v = '0;
        eval(); adv();
        idle_inputs();

        // Randomized traffic against the model, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(63) == 0);
            cmd_v = N'($urandom);
            dev_cmd_rdy = 1'($urandom_range(1));
            for (int i = 0; i < N; i++) begin
                cmd_hdr[i] = {$urandom, $urandom};
                cmd_crit[i] = {$urandom, $urandom};
            end
            dev_resp_v = 1'($urandom_range(1));
            resp_rdy = N'($urandom);
            dev_resp_hdr = {$urandom, $urandom};
            dev_resp_crit = {$urandom, $urandom};
            if (m_busy && m_age >= 4) begin dev_resp_v = 1'b1; resp_rdy = '1; end
            eval(); adv();
        end
        reset = 1'b0;
        idle_inputs();

`ifdef BP_ME_REG_ARB_WATCHDOG_EN
        // Device never answers: synthesized response, then late reply dropped.
        reset = 1'b1; eval(); adv(); reset = 1'b0;
        cmd_v = 2'b01; dev_cmd_rdy = 1'b1; cmd_hdr[0] = 64'h0000_0000_0000_0ABC;
        eval(); adv();
        idle_inputs(); resp_rdy = 2'b01;
        for (int k = 1; k < 8; k++) begin
            eval(); chk("t5_wait", 64'(resp_v_o), 64'h0); adv();
        end
        eval();
        chk("t5_err_v", 64'(resp_v_o), 64'h1);
        chk("t5_err_crit", resp_crit_o, DEAD);
        chk("t5_err_hdr", resp_hdr_o, 64'h0ABC);
        adv();
        dev_resp_v = 1'b1; dev_resp_crit = 64'h55;
        eval(); chk("t5_drop_rdy", 64'(dev_rrdy_o), 64'h1); chk("t5_drop_v", 64'(resp_v_o), 64'h0); adv();
        dev_resp_v = 1'b0; cmd_v = 2'b10; dev_cmd_rdy = 1'b1;
        eval(); chk("t5_next_grant", 64'(cmd_rdy_o), 64'h2); adv();
        cmd_v = '0; dev_resp_v = 1'b1; dev_resp_crit = 64'h77; resp_rdy = 2'b10;
        eval(); chk("t5_next_v", 64'(resp_v_o), 64'h2); chk("t5_next_crit", resp_crit_o, 64'h77); adv();
        idle_inputs();
`endif

        eval(); adv();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
